// File: rtl/clock_pkg.sv
// Shared definitions for the clock-time UART transmitter: bit FSM states,
// ASCII constants, the default baud divider and the digit-to-ASCII mapping.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int DEFAULT_BAUD_DIV = 434;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Non-decimal nibbles print as '?' so a corrupt digit is visible on the terminal.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    if (d <= 4'd9) return ASCII_ZERO + {4'h0, d};
    return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Handshake: a byte transfers on a cycle where
// i_byte_valid and o_byte_ready are both high; ready never depends on valid.
module uart_tx_byte
  import clock_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  output logic       o_byte_ready,
  output logic       o_tx,
  output tx_state_e  o_state
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  tx_state_e      r_state, w_state_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic [2:0]     r_bit, w_bit_d;
  logic [7:0]     r_shift, w_shift_d;
  logic           r_tx, w_tx_d;
  logic           w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign o_tx      = r_tx;
  assign o_state   = r_state;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_bit_d      = r_bit;
    w_shift_d    = r_shift;
    w_tx_d       = r_tx;
    o_byte_ready = 1'b0;
    if (r_state != ST_IDLE) w_cnt_d = w_bit_end ? '0 : r_cnt + 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        o_byte_ready = 1'b1;
        w_tx_d       = 1'b1;
        if (i_byte_valid) begin
          w_shift_d = i_byte_data;
          w_state_d = ST_START;
          w_tx_d    = 1'b0;
          w_cnt_d   = '0;
        end
      end
      ST_START: if (w_bit_end) begin
        w_state_d = ST_DATA;
        w_tx_d    = r_shift[0];
        w_bit_d   = 3'd0;
      end
      ST_DATA: if (w_bit_end) begin
        if (r_bit == 3'd7) begin
          w_state_d = ST_STOP;
          w_tx_d    = 1'b1;
        end else begin
          // shift[0] always holds the bit on the line; shift[1] is the next one.
          w_shift_d = r_shift >> 1;
          w_tx_d    = r_shift[1];
          w_bit_d   = r_bit + 3'd1;
        end
      end
      ST_STOP: if (w_bit_end) begin
        o_byte_ready = 1'b1;
        if (i_byte_valid) begin
          w_shift_d = i_byte_data;
          w_state_d = ST_START;
          w_tx_d    = 1'b0;
        end else begin
          w_state_d = ST_IDLE;
          w_tx_d    = 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
    end
  end

endmodule

// File: rtl/clock_time_uart_tx.sv
// Sends "HH:MM:SS\r\n" over UART on request: snapshots the digits, sequences
// the ten bytes and feeds them to the byte serialiser without gaps.
module clock_time_uart_tx
  import clock_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [3:0] bcd_H1,
  input  logic [3:0] bcd_H2,
  input  logic [3:0] bcd_M1,
  input  logic [3:0] bcd_M2,
  input  logic [3:0] bcd_S1,
  input  logic [3:0] bcd_S2,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  logic [3:0] r_h1, r_h2, r_m1, r_m2, r_s1, r_s2;
  logic [3:0] r_idx;
  logic       r_busy, r_done;

  logic       w_accept, w_step, w_more, w_byte_valid, w_byte_ready;
  logic [3:0] w_next_idx;
  logic [7:0] w_seq_data, w_byte_data;
  tx_state_e  w_state;

  assign w_accept     = send & ~r_busy;
  assign w_step       = r_busy & w_byte_ready & (w_state == ST_STOP);
  assign w_more       = (r_idx != 4'd9);
  assign w_next_idx   = r_idx + 4'd1;
  assign w_byte_valid = w_accept | (w_step & w_more);
  // Byte 0 comes from the live inputs so its start bit goes out right after accept.
  assign w_byte_data  = w_accept ? bcd_to_ascii(bcd_H1) : w_seq_data;

  always_comb begin
    w_seq_data = ASCII_LF;
    case (w_next_idx)
      4'd0:    w_seq_data = bcd_to_ascii(r_h1);
      4'd1:    w_seq_data = bcd_to_ascii(r_h2);
      4'd2:    w_seq_data = ASCII_COLON;
      4'd3:    w_seq_data = bcd_to_ascii(r_m1);
      4'd4:    w_seq_data = bcd_to_ascii(r_m2);
      4'd5:    w_seq_data = ASCII_COLON;
      4'd6:    w_seq_data = bcd_to_ascii(r_s1);
      4'd7:    w_seq_data = bcd_to_ascii(r_s2);
      4'd8:    w_seq_data = ASCII_CR;
      default: w_seq_data = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1   <= 4'd0;
      r_h2   <= 4'd0;
      r_m1   <= 4'd0;
      r_m2   <= 4'd0;
      r_s1   <= 4'd0;
      r_s2   <= 4'd0;
      r_idx  <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_h1   <= bcd_H1;
        r_h2   <= bcd_H2;
        r_m1   <= bcd_M1;
        r_m2   <= bcd_M2;
        r_s1   <= bcd_S1;
        r_s2   <= bcd_S2;
        r_idx  <= 4'd0;
        r_busy <= 1'b1;
      end else if (w_step) begin
        if (w_more) begin
          r_idx <= w_next_idx;
        end else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_byte_valid (w_byte_valid),
    .i_byte_data  (w_byte_data),
    .o_byte_ready (w_byte_ready),
    .o_tx         (tx),
    .o_state      (w_state)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_clock_time_uart_tx.sv
// Bench for clock_time_uart_tx: a UART receiver model decodes tx and checks
// each byte against an expected queue; scenario tasks check timing and flags.
module tb_clock_time_uart_tx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send, send_f;
  logic [3:0] h1, h2, m1, m2, s1, s2;
  logic       tx, busy, done;
  logic       tx_f, busy_f, done_f;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;

  bit         rx_busy = 0;
  int         rx_cnt, rx_bit;
  int         rx_count = 0;
  logic [7:0] rx_byte, rx_exp;

  always #5 clk = ~clk;

  clock_time_uart_tx #(.BAUD_DIV(BD)) u_dut (
    .clk(clk), .rst_n(rst_n), .send(send),
    .bcd_H1(h1), .bcd_H2(h2), .bcd_M1(m1), .bcd_M2(m2), .bcd_S1(s1), .bcd_S2(s2),
    .tx(tx), .busy(busy), .done(done)
  );

  clock_time_uart_tx u_full (
    .clk(clk), .rst_n(rst_n), .send(send_f),
    .bcd_H1(h1), .bcd_H2(h2), .bcd_M1(m1), .bcd_M2(m2), .bcd_S1(s1), .bcd_S2(s2),
    .tx(tx_f), .busy(busy_f), .done(done_f)
  );

  // Receiver model: start detected at cycle 0, bits sampled mid-period.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BD == BD / 2) begin
        rx_bit = rx_cnt / BD;
        if (rx_bit >= 1 && rx_bit <= 8) begin
          rx_byte[rx_bit-1] = tx;
        end else if (rx_bit == 9) begin
          rx_count++;
          n_vec++;
          if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL stop_bit: got %b want 1 (byte %0d)", tx, rx_count);
          end
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: got %02h want none", rx_byte);
          end else begin
            rx_exp = exp_q.pop_front();
            if (rx_byte !== rx_exp) begin
              n_err++;
              $display("FAIL rx_byte: got %02h want %02h", rx_byte, rx_exp);
            end
          end
          rx_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

  function automatic logic [7:0] asc(input logic [3:0] d);
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    return 8'h3F;
  endfunction

  task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
    h1 = a; h2 = b; m1 = c; m2 = d; s1 = e; s2 = f;
  endtask

  task automatic push_seq();
    exp_q.push_back(asc(h1)); exp_q.push_back(asc(h2)); exp_q.push_back(8'h3A);
    exp_q.push_back(asc(m1)); exp_q.push_back(asc(m2)); exp_q.push_back(8'h3A);
    exp_q.push_back(asc(s1)); exp_q.push_back(asc(s2));
    exp_q.push_back(8'h0D);   exp_q.push_back(8'h0A);
  endtask

  // Returns at the negedge of the first busy cycle.
  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Counts busy cycles (current negedge included); stops at the first non-busy negedge.
  task automatic wait_idle(input int bound, output int len, output bit timed_out);
    len = 1;
    timed_out = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        timed_out = 0;
        break;
      end
      len++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      send = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
      end
    end
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || tx !== 1'b1 || rx_count != 0) begin
      n_err++;
      $display("FAIL reset_send_ignored: got busy=%b tx=%b bytes=%0d want 0 1 0", busy, tx, rx_count);
    end
  endtask

  task automatic test_basic();
    int len; bit to;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    push_seq();
    pulse_send();
    n_vec++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_start: got tx=%b busy=%b want 0 1", tx, busy);
    end
    wait_idle(1000, len, to);
    n_vec++;
    if (to || len != 100 * BD) begin
      n_err++;
      $display("FAIL basic_busy_len: got %0d (timeout=%0d) want %0d", len, to, 100 * BD);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done: got %b want 1", done);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width: got %b want 0", done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_all_bytes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_snapshot();
    int len, d0; bit to;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    push_seq();
    d0 = done_cnt;
    pulse_send();
    repeat (100) @(negedge clk);
    set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    pulse_send();
    wait_idle(1000, len, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL snap_timeout: got timeout want idle");
    end
    repeat (60) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL snap_no_requeue: got busy=%b tx=%b want 0 1", busy, tx);
    end
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL snap_done_count: got %0d want 1", done_cnt - d0);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL snap_all_bytes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_qmark();
    int len; bit to;
    set_digits(4'hA, 4'hF, 4'd0, 4'd0, 4'd0, 4'd0);
    push_seq();
    pulse_send();
    wait_idle(1000, len, to);
    n_vec++;
    if (to || len != 100 * BD) begin
      n_err++;
      $display("FAIL qmark_busy_len: got %0d want %0d", len, 100 * BD);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL qmark_all_bytes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int len, d0; bit to;
    set_digits(4'd7, 4'd8, 4'd5, 4'd9, 4'd3, 4'd1);
    push_seq();
    d0 = done_cnt;
    pulse_send();
    repeat (149) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    n_vec++;
    if (exp_q.size() != 7) begin
      n_err++;
      $display("FAIL midreset_bytes_sent: got %0d left want 7", exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_done: got done_pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0);
    push_seq();
    pulse_send();
    n_vec++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_restart: got tx=%b want 0", tx);
    end
    wait_idle(1000, len, to);
    n_vec++;
    if (to || len != 100 * BD || done !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_full_seq: got len=%0d done=%b want %0d 1", len, done, 100 * BD);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_all_bytes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int len; bit to;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    push_seq();
    pulse_send();
    wait_idle(1000, len, to);
    n_vec++;
    if (to || done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_done: got done=%b timeout=%0d want 1 0", done, to);
    end
    set_digits(4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 4'd9);
    push_seq();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n_vec++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart: got tx=%b busy=%b want 0 1", tx, busy);
    end
    wait_idle(1000, len, to);
    n_vec++;
    if (to || len != 100 * BD || done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_seq: got len=%0d done=%b want %0d 1", len, done, 100 * BD);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_all_bytes: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_full_rate();
    int len;
    bit to;
    @(negedge clk);
    send_f = 1'b1;
    @(negedge clk);
    send_f = 1'b0;
    n_vec++;
    if (tx_f !== 1'b0 || busy_f !== 1'b1) begin
      n_err++;
      $display("FAIL full_start: got tx=%b busy=%b want 0 1", tx_f, busy_f);
    end
    len = 1;
    to = 1;
    for (int i = 0; i < 50000; i++) begin
      @(negedge clk);
      if (busy_f !== 1'b1) begin
        to = 0;
        break;
      end
      len++;
    end
    n_vec++;
    if (to || len != 43400 || done_f !== 1'b1) begin
      n_err++;
      $display("FAIL full_seq_len: got len=%0d done=%b want 43400 1", len, done_f);
    end
  endtask

  initial begin
    send = 1'b0;
    send_f = 1'b0;
    rst_n = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_basic();
    test_snapshot();
    test_qmark();
    test_reset_mid();
    test_back_to_back();
    test_full_rate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
